load_store_unit: RTL

Load/store unit sitting directly upstream of `data_memory`: it accepts one load or store request at a time from the datapath and drives `data_memory`'s `mem_write`/`mem_read`/`mem_size`/`address`/`write_data` ports. It returns sign- or zero-extended load data. Misaligned halfword/word accesses are split into sequential byte beats, so `data_memory` only ever sees naturally aligned accesses. Reserved sizes are rejected without touching memory.

---
 rtl/load_store_unit_pkg.sv | 28 ++
 rtl/load_store_unit_load_extend.sv | 21 ++
 rtl/load_store_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - size/state encodings and alignment helper for the load/store unit
package load_store_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_t;

   // Reserved size is reported as not aligned; callers screen it out separately.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (size)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = ~addr_lo[0];
         SIZE_WORD: ok = (addr_lo == 2'b00);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - sign/zero extension of assembled load data
module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] ext_data
);

   always_comb begin
      ext_data = '0;
      case (size)
         SIZE_BYTE: ext_data = {{24{~is_unsigned & data[7]}}, data[7:0]};
         SIZE_HALF: ext_data = {{16{~is_unsigned & data[15]}}, data[15:0]};
         SIZE_WORD: ext_data = data;
         default:   ext_data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit in front of data_memory
// Misaligned half/word accesses are split into little-endian byte beats.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error,
   output logic              mem_write,
   output logic              mem_read,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   lsu_state_t        state, state_nxt;
   logic              write_q, unsigned_q, split_q, error_q;
   logic [1:0]        size_q, last_q, k_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, ext_data;
   logic              accept, last_beat, req_rsvd, req_split;

   assign accept    = (state == ST_IDLE) && req_valid;
   assign last_beat = (k_q == last_q);
   assign req_rsvd  = (req_size == SIZE_RSVD);
   assign req_split = !is_aligned(req_size, req_addr[1:0]) && !req_rsvd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         split_q    <= 1'b0;
         error_q    <= 1'b0;
         size_q     <= '0;
         last_q     <= '0;
         k_q        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            error_q    <= req_rsvd;
            split_q    <= req_split;
            last_q     <= req_split ? ((req_size == SIZE_HALF) ? 2'd1 : 2'd3) : 2'd0;
            k_q        <= '0;
            rdata_q    <= '0;
         end else if (state == ST_ACCESS) begin
            k_q <= k_q + 2'd1;
            if (!write_q) begin
               // Split beats fill one byte lane each; aligned beats take the whole word.
               if (split_q) rdata_q[{k_q, 3'b000} +: 8] <= read_data[7:0];
               else         rdata_q <= read_data;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_valid) state_nxt = req_rsvd ? ST_RESP : ST_ACCESS;
         ST_ACCESS: if (last_beat) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   load_extend u_load_extend (
      .data       (rdata_q),
      .size       (size_q),
      .is_unsigned(unsigned_q),
      .ext_data   (ext_data)
   );

   always_comb begin
      req_ready  = (state == ST_IDLE);
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      mem_size   = '0;
      address    = '0;
      write_data = '0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_error = 1'b0;
      if (state == ST_ACCESS) begin
         mem_write = write_q;
         mem_read  = ~write_q;
         if (split_q) begin
            mem_size   = SIZE_BYTE;
            address    = addr_q + ADDR_W'(k_q);
            write_data = {{(DATA_W-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]};
         end else begin
            mem_size   = size_q;
            address    = addr_q;
            write_data = wdata_q;
         end
      end
      if (state == ST_RESP) begin
         resp_valid = 1'b1;
         resp_error = error_q;
         resp_rdata = (write_q || error_q) ? '0 : ext_data;
      end
   end

endmodule
